// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//
// Round-robin scan controller that drives the select lines of a downstream
// 4:1 sample mux. Requesting channels are granted in turn. Each grant lasts
// (dwell + 1) accepted transfers, and an idle bubble always separates two
// grants. Every output comes straight from a flop.
//
// Parameters
//   DWELL_W  width of the dwell input and the internal transfer counter (1..8)
//
// Ports
//   clk      input   rising-edge clock
//   rst_n    input   asynchronous active-low reset
//   req      input   [3:0] per-channel service request (bit k = channel k)
//   dwell    input   [DWELL_W-1:0] transfers per grant minus one, sampled at grant start
//   ready    input   downstream accepts the selected sample this cycle
//   lock     input   hold the current grant (only with SCAN_LOCK_EN defined)
//   s1       output  select bit 0 to the downstream mux
//   s2       output  select bit 1 to the downstream mux
//   gnt      output  [3:0] one-hot grant, zero while not valid
//   valid    output  selection is active
//   last     output  final transfer cycle of the current grant
//
// Build option
//   SCAN_LOCK_EN  when defined, adds the lock input. While lock is high the
//                 grant neither completes nor aborts and the counter is held.

module mux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               ready,
`ifdef SCAN_LOCK_EN
    input  logic               lock,
`endif
    output logic               s1,
    output logic               s2,
    output logic [3:0]         gnt,
    output logic               valid,
    output logic               last
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] count_q, count_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic               lockActive;
    logic [1:0]         candIdx;
    logic [1:0]         pickIdx;
    logic               pickFound;

    // Without the lock option the hold condition is tied off, so the
    // HOLD logic below is identical in both builds.
`ifdef SCAN_LOCK_EN
    assign lockActive = lock;
`else
    assign lockActive = 1'b0;
`endif

    // Round-robin search. It starts one past the last granted channel and
    // ends on that channel itself. The pointer therefore resets to 3, so
    // the first search after reset begins at channel 0.
    always_comb begin
        candIdx   = ptr_q;
        pickIdx   = ptr_q;
        pickFound = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            candIdx = ptr_q + 2'(i);
            if (!pickFound && req[candIdx]) begin
                pickIdx   = candIdx;
                pickFound = 1'b1;
            end
        end
    end

    // Next-state logic. IDLE starts a grant and loads the dwell count.
    // In HOLD each accepted transfer decrements the counter, which stops
    // at zero. The grant finishes on the transfer that finds the counter
    // at zero, or earlier if the granted channel withdraws its request.
    // Either way, ptr records the channel just served. The outputs are
    // computed from the next state so that each one can be registered.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;

        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    sel_d   = pickIdx;
                    count_d = dwell;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!lockActive) begin
                    if (ready && (count_q != '0)) begin
                        count_d = count_q - DWELL_W'(1);
                    end
                    if (!req[sel_q] || (ready && (count_q == '0))) begin
                        state_d = IDLE;
                        ptr_d   = sel_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == HOLD);
        gnt_d   = valid_d ? (4'b0001 << sel_d) : 4'b0000;
        last_d  = valid_d && (count_d == '0);
    end

    // State and output registers. The asynchronous reset clears the
    // visible outputs at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign s1    = sel_q[0];
    assign s2    = sel_q[1];
    assign gnt   = gnt_q;
    assign valid = valid_q;
    assign last  = last_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
//
// Directed testbench for mux_scan_ctrl. Inputs change 1 ns after each
// rising edge, and outputs are sampled at that same point. Each observed
// output bundle is {valid, last, s2, s1, gnt}.

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] dwell;
    logic       ready;
`ifdef SCAN_LOCK_EN
    logic       lock;
`endif
    logic       s1;
    logic       s2;
    logic [3:0] gnt;
    logic       valid;
    logic       last;
    logic [7:0] obs;
    logic [7:0] expv;

    int errors = 0;
    int checks = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    assign obs = {valid, last, s2, s1, gnt};

    mux_scan_ctrl #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .dwell (dwell),
        .ready (ready),
`ifdef SCAN_LOCK_EN
        .lock  (lock),
`endif
        .s1    (s1),
        .s2    (s2),
        .gnt   (gnt),
        .valid (valid),
        .last  (last)
    );

    // Builds the expected {valid,last,s2,s1,gnt}. gnt is one-hot only while valid.
    function automatic logic [7:0] expOut(input logic v, input logic l, input int ch);
        logic [1:0] c;
        c = 2'(ch);
        return {v, l, c, v ? (4'b0001 << c) : 4'b0000};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset holds everything at zero, and the outputs stay idle after
    // release while nothing is requested.
    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        dwell = 4'd0;
        ready = 1'b0;
`ifdef SCAN_LOCK_EN
        lock  = 1'b0;
`endif
        tick();
        tick();
        expv = expOut(1'b0, 1'b0, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, expv);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL post_release_idle: got %b expected %b", obs, expv);
        end
    endtask

    // All four channels request with dwell 0. Expect grants 0,1,2,3,0,
    // with an idle bubble after each one.
    task automatic test_round_robin();
        req   = 4'b1111;
        dwell = 4'd0;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expv = expOut(1'b1, 1'b1, k % 4);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rr_grant k=%0d: got %b expected %b", k, obs, expv);
            end
            tick();
            expv = expOut(1'b0, 1'b0, k % 4);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rr_bubble k=%0d: got %b expected %b", k, obs, expv);
            end
            if (k == 4) req = 4'b0000;
        end
    endtask

    // Channel 2 with dwell 2 and ready toggling 1,0,1,0,1 holds valid for
    // 5 cycles. The counter reaches 0 after the second accepted transfer,
    // so last is high on cycles 4 and 5. A lone requester is then
    // re-granted after the bubble.
    task automatic test_dwell_backpressure();
        logic [4:0] pat;
        pat   = 5'b10101;
        req   = 4'b0100;
        dwell = 4'd2;
        ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            expv = expOut(1'b1, (i >= 3), 2);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL bp_hold i=%0d: got %b expected %b", i, obs, expv);
            end
            ready = pat[i];
            tick();
        end
        expv = expOut(1'b0, 1'b0, 2);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL bp_end: got %b expected %b", obs, expv);
        end
        ready = 1'b1;
        dwell = 4'd0;
        tick();
        expv = expOut(1'b1, 1'b1, 2);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL single_regrant: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
        expv = expOut(1'b0, 1'b0, 2);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL single_end: got %b expected %b", obs, expv);
        end
    endtask

    // Channel 1 is granted with dwell 7. Its request drops after two
    // transfers while channel 3 is requesting. Expect an idle cycle,
    // then a grant to channel 3.
    task automatic test_abort();
        req   = 4'b0010;
        dwell = 4'd7;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expv = expOut(1'b1, 1'b0, 1);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL abort_hold i=%0d: got %b expected %b", i, obs, expv);
            end
        end
        req = 4'b1000;
        tick();
        expv = expOut(1'b0, 1'b0, 1);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL abort_idle: got %b expected %b", obs, expv);
        end
        tick();
        expv = expOut(1'b1, 1'b0, 3);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL abort_next: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
        expv = expOut(1'b0, 1'b0, 3);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL abort_end: got %b expected %b", obs, expv);
        end
    endtask

    // With ptr at 0 and req 1001, channel 3 wins before channel 0.
    task automatic test_skip();
        req   = 4'b0001;
        dwell = 4'd0;
        ready = 1'b1;
        tick();
        expv = expOut(1'b1, 1'b1, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL skip_setup: got %b expected %b", obs, expv);
        end
        tick();
        req = 4'b1001;
        tick();
        expv = expOut(1'b1, 1'b1, 3);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL skip_ch3_first: got %b expected %b", obs, expv);
        end
        tick();
        tick();
        expv = expOut(1'b1, 1'b1, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL skip_ch0_after: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
    endtask

    // Changing dwell mid-grant must not stretch the current grant.
    task automatic test_dwell_change();
        req   = 4'b0010;
        dwell = 4'd1;
        ready = 1'b1;
        tick();
        expv = expOut(1'b1, 1'b0, 1);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL dwell_start: got %b expected %b", obs, expv);
        end
        dwell = 4'd5;
        tick();
        expv = expOut(1'b1, 1'b1, 1);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL dwell_change_last: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
        expv = expOut(1'b0, 1'b0, 1);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL dwell_change_end: got %b expected %b", obs, expv);
        end
    endtask

    // Reset asserted mid-grant clears the outputs before the next edge.
    // After release, the search restarts from channel 0.
    task automatic test_reset_mid_hold();
        req   = 4'b0001;
        dwell = 4'd7;
        ready = 1'b1;
        tick();
        expv = expOut(1'b1, 1'b0, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL pre_reset_hold: got %b expected %b", obs, expv);
        end
        #2;
        rst_n = 1'b0;
        #1;
        expv = expOut(1'b0, 1'b0, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs, expv);
        end
        tick();
        rst_n = 1'b1;
        req   = 4'b1000;
        tick();
        expv = expOut(1'b1, 1'b0, 3);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL post_reset_grant: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
        req   = 4'b0010;
        dwell = 4'd0;
        tick();
        tick();
        req = 4'b0000;
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        expv = expOut(1'b1, 1'b1, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_ptr_restart: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
    endtask

`ifdef SCAN_LOCK_EN
    // Lock holds a dwell-0 grant on channel 2 for four cycles, even after
    // its request drops. The grant ends in the cycle after lock falls.
    task automatic test_lock();
        req   = 4'b0100;
        dwell = 4'd0;
        ready = 1'b1;
        lock  = 1'b0;
        tick();
        expv = expOut(1'b1, 1'b1, 2);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL lock_grant: got %b expected %b", obs, expv);
        end
        lock = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL lock_hold i=%0d: got %b expected %b", i, obs, expv);
            end
            if (i == 1) req = 4'b0000;
            if (i == 4) lock = 1'b0;
        end
        tick();
        expv = expOut(1'b0, 1'b0, 2);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL lock_end: got %b expected %b", obs, expv);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_dwell_backpressure();
        test_abort();
        test_skip();
        test_dwell_change();
        test_reset_mid_hold();
`ifdef SCAN_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 4, SHALL set the width of the dwell count input and internal counter (legal 1..8).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, SHALL be asynchronous and active-low.
REQ-004 req  input  4  per-channel service request; bit k = channel k (channel 0 = i1 path of the downstream 4:1 mux).
REQ-005 dwell  input  DWELL_W  transfers per grant minus 1, sampled only at grant start.
REQ-006 ready  input  1  downstream accepts the current selected sample this cycle.
REQ-007 lock  input  1  hold current grant (present only when SCAN_LOCK_EN is defined).
REQ-008 s1  output  1  select bit 0 to the downstream mux.
REQ-009 s2  output  1  select bit 1; {s2,s1} SHALL equal the granted channel index.
REQ-010 gnt  output  4  one-hot grant, equal to decoded {s2,s1} when valid=1, else 0.
REQ-011 valid  output  1  selection is active and the mux output is a sample.
REQ-012 last  output  1  high on the final transfer cycle of the current grant.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 FSM states SHALL be IDLE and HOLD only.
REQ-015 IDLE: valid=0, gnt=0; s1/s2 SHALL hold the last granted index.
REQ-016 IDLE with req!=0: next channel SHALL be the first requester searching ptr+1, ptr+2, ptr+3, ptr (mod 4); counter loads dwell; state HOLD next cycle (req->valid latency 1 cycle).
REQ-017 HOLD: valid=1; a transfer SHALL occur on each cycle with valid=1 and ready=1; the counter SHALL decrement by 1 per transfer and never wrap below 0.
REQ-018 last SHALL be 1 when in HOLD with counter==0, irrespective of ready.
REQ-019 Transfer with counter==0: ptr SHALL take the granted index and state SHALL return to IDLE (one idle bubble between grants, even if req remains).
REQ-020 ready=0 in HOLD SHALL freeze counter, select bits and state.
REQ-021 req bit of the granted channel dropping in HOLD SHALL abort the grant: IDLE next cycle, ptr updated to the granted index, pending transfer that cycle still counted if ready=1.
REQ-022 dwell changes during HOLD SHALL have no effect until the next grant.
REQ-023 Single requester: that channel SHALL be re-granted after each bubble.

Reset
REQ-024 While rst_n=0: state IDLE, s1=0, s2=0, gnt=0, valid=0, last=0, counter=0, ptr=3 (first search starts at channel 0).
REQ-025 Reset asserted mid-HOLD SHALL clear all outputs immediately, without waiting for clk; first grant after release SHALL again search from channel 0.

Configuration
REQ-026 Macro SCAN_LOCK_EN SHALL control the lock feature.
REQ-027 Defined: lock port exists; lock=1 in HOLD SHALL freeze the counter and block both completion (REQ-019) and abort (REQ-021) while transfers with ready=1 still occur; lock in IDLE SHALL be ignored.
REQ-028 Not defined: lock port SHALL be absent and behaviour SHALL be as REQ-013..023.

Verification
REQ-029 Reset mid-HOLD: assert rst_n=0 asynchronously -> valid=0, gnt=0, {s2,s1}=0 before next edge; release with req=4'b1000 -> gnt=4'b1000 after 1 cycle.
REQ-030 Round-robin: req=4'b1111, dwell=0, ready=1 -> grants 0,1,2,3,0 with one IDLE cycle between each.
REQ-031 Dwell/backpressure: req=4'b0100, dwell=2, ready toggling 1,0,1,0,1 -> valid held 5 cycles, last high on 5th, {s2,s1}=2 throughout.
REQ-032 Abort: grant channel 1 with dwell=7, drop req[1] after 2 transfers, req[3]=1 -> IDLE next cycle, then gnt=4'b1000.
REQ-033 Skip: ptr=0, req=4'b1001 -> channel 3 granted before channel 0.
REQ-034 SCAN_LOCK_EN: channel 2, dwell=0, lock=1 for 4 cycles with ready=1 -> valid stays 1, 4 transfers, grant ends the cycle after lock drops.
